// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encodings,
// requester IDs and the wait-counter width.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_LDR = 1'b1
    } req_id_e;

    localparam int unsigned WAIT_CNT_W = 4;

    // bit 1 of the one-hot grant selects the loader; anything else is the CPU
    function automatic req_id_e onehot_to_id(input logic [1:0] grant);
        return grant[1] ? REQ_LDR : REQ_CPU;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU port, the loader port and the shared memory port.
// The slave modport is the arbiter's view; master is the requesters/memory side.
interface mem_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [DATA_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ack;
    logic                  cpu_stall;

    logic                  ldr_req;
    logic                  ldr_we;
    logic [DATA_WIDTH-1:0] ldr_addr;
    logic [DATA_WIDTH-1:0] ldr_wdata;
    logic [DATA_WIDTH-1:0] ldr_rdata;
    logic                  ldr_ack;

    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_rdata, ldr_ack,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_rdata, ldr_ack,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_rr_grant2.sv
// Two-way round-robin grant: a lone request always wins; on a tie the
// requester that was not granted last wins.
module rr_grant2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  req_id_e    i_last,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = '0;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (i_last == REQ_CPU) ? 2'b10 : 2'b01;
            default: o_grant = '0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the multicycle CPU and the loader/debug port.
// IDLE grants and latches a request, ACCESS waits WAIT_STATES+1 cycles, RESP acks.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [WAIT_CNT_W-1:0] WS = WAIT_CNT_W'(WAIT_STATES);

    arb_state_e r_state;
    arb_state_e w_next;

    logic [WAIT_CNT_W-1:0] r_cnt;
    req_id_e               r_gnt;
    req_id_e               r_last;
    logic                  r_we;
    logic                  r_first;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [DATA_WIDTH-1:0] r_ldr_rdata;

    logic [1:0] w_req;
    logic [1:0] w_grant;
    req_id_e    w_gnt_id;
    logic       w_mem_we;
    logic       w_cpu_ack;
    logic       w_ldr_ack;

    assign w_req = {bus.ldr_req, bus.cpu_req};

    rr_grant2 u_rr_grant2 (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    assign w_gnt_id = onehot_to_id(w_grant);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (|w_req) w_next = ST_ACCESS;
            ST_ACCESS: if (r_cnt == '0) w_next = ST_RESP;
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // r_last resets to LDR so that the first tie after reset goes to the CPU
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_gnt       <= REQ_CPU;
            r_last      <= REQ_LDR;
            r_we        <= 1'b0;
            r_first     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_ldr_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_gnt   <= w_gnt_id;
                        r_last  <= w_gnt_id;
                        r_cnt   <= WS;
                        r_first <= 1'b1;
                        if (w_gnt_id == REQ_LDR) begin
                            r_we    <= bus.ldr_we;
                            r_addr  <= bus.ldr_addr;
                            r_wdata <= bus.ldr_wdata;
                        end else begin
                            r_we    <= bus.cpu_we;
                            r_addr  <= bus.cpu_addr;
                            r_wdata <= bus.cpu_wdata;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_first <= 1'b0;
                    if (r_cnt == '0) begin
                        if (r_gnt == REQ_LDR) begin
                            r_ldr_rdata <= bus.mem_rdata;
                        end else begin
                            r_cpu_rdata <= bus.mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Decoded from registered state, so reset clears these without waiting for a clock
    always_comb begin
        w_mem_we  = 1'b0;
        w_cpu_ack = 1'b0;
        w_ldr_ack = 1'b0;
        case (r_state)
            ST_ACCESS: w_mem_we = r_first & r_we;
            ST_RESP: begin
                w_cpu_ack = (r_gnt == REQ_CPU);
                w_ldr_ack = (r_gnt == REQ_LDR);
            end
            default: begin
            end
        endcase
    end

    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.ldr_rdata = r_ldr_rdata;
    assign bus.cpu_ack   = w_cpu_ack;
    assign bus.ldr_ack   = w_ldr_ack;
    assign bus.cpu_stall = bus.cpu_req & ~w_cpu_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances with WAIT_STATES of 1, 3 and 0
// share one clock and reset; each scenario task checks its own expectations.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mem_port_arbiter_if #(.DATA_WIDTH(32)) b0 ();
    mem_port_arbiter_if #(.DATA_WIDTH(32)) b3 ();
    mem_port_arbiter_if #(.DATA_WIDTH(32)) bz ();

    mem_port_arbiter #(.WAIT_STATES(1), .DATA_WIDTH(32)) u0 (.clk(clk), .reset(reset), .bus(b0));
    mem_port_arbiter #(.WAIT_STATES(3), .DATA_WIDTH(32)) u3 (.clk(clk), .reset(reset), .bus(b3));
    mem_port_arbiter #(.WAIT_STATES(0), .DATA_WIDTH(32)) uz (.clk(clk), .reset(reset), .bus(bz));

    // Memory model: 0x10 reads DEADBEEF, every other address reads addr ^ CAFE0000
    assign b0.mem_rdata = (b0.mem_addr == 32'h10) ? 32'hDEAD_BEEF : (b0.mem_addr ^ 32'hCAFE_0000);
    assign b3.mem_rdata = (b3.mem_addr == 32'h10) ? 32'hDEAD_BEEF : (b3.mem_addr ^ 32'hCAFE_0000);
    assign bz.mem_rdata = (bz.mem_addr == 32'h10) ? 32'hDEAD_BEEF : (bz.mem_addr ^ 32'hCAFE_0000);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (b0.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", b0.mem_we); end
        checks++; if (b0.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", b0.mem_addr); end
        checks++; if (b0.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h exp 0", b0.mem_wdata); end
        checks++; if (b0.cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_cpu_rdata got %h exp 0", b0.cpu_rdata); end
        checks++; if (b0.ldr_rdata !== 32'h0) begin errors++; $display("FAIL reset_ldr_rdata got %h exp 0", b0.ldr_rdata); end
        checks++; if ({b0.cpu_ack, b0.ldr_ack, b3.cpu_ack, bz.ldr_ack} !== 4'b0) begin
            errors++; $display("FAIL reset_acks got %b exp 0000", {b0.cpu_ack, b0.ldr_ack, b3.cpu_ack, bz.ldr_ack});
        end
        tick();
        reset = 1'b0;
        tick();
        checks++; if (b0.cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_idle_ack got %b exp 0", b0.cpu_ack); end
    endtask

    task automatic test_cpu_read();
        int lat = 0;
        int stall_cnt = 0;
        int we_cnt = 0;
        bit got = 0;
        b0.cpu_we   = 1'b0;
        b0.cpu_addr = 32'h0000_0010;
        b0.cpu_req  = 1'b1;
        #1;
        for (int i = 0; i < 12 && !got; i++) begin
            if (b0.cpu_stall) stall_cnt++;
            tick();
            lat++;
            if (b0.mem_we) we_cnt++;
            if (b0.cpu_ack) got = 1;
        end
        checks++; if (lat != 3 || !got) begin errors++; $display("FAIL cpu_read_latency got %0d (ack %0d) exp 3", lat, got); end
        checks++; if (stall_cnt != 3) begin errors++; $display("FAIL cpu_read_stall_cycles got %0d exp 3", stall_cnt); end
        checks++; if (b0.cpu_stall !== 1'b0) begin errors++; $display("FAIL cpu_read_stall_at_ack got %b exp 0", b0.cpu_stall); end
        checks++; if (b0.cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cpu_read_rdata got %h exp deadbeef", b0.cpu_rdata); end
        checks++; if (b0.ldr_ack !== 1'b0) begin errors++; $display("FAIL cpu_read_ldr_ack got %b exp 0", b0.ldr_ack); end
        checks++; if (we_cnt != 0) begin errors++; $display("FAIL cpu_read_mem_we got %0d exp 0", we_cnt); end
        checks++; if (b0.mem_addr !== 32'h10) begin errors++; $display("FAIL cpu_read_mem_addr got %h exp 10", b0.mem_addr); end
        b0.cpu_req = 1'b0;
        tick();
        checks++; if (b0.cpu_ack !== 1'b0) begin errors++; $display("FAIL cpu_read_ack_pulse got %b exp 0", b0.cpu_ack); end
    endtask

    task automatic test_round_robin();
        int who[3];
        int when_t[3];
        int n_ack = 0;
        int overlap = 0;
        for (int k = 0; k < 3; k++) begin who[k] = -1; when_t[k] = -1; end
        pulse_reset();
        b0.cpu_we = 1'b0; b0.cpu_addr = 32'h20;
        b0.ldr_we = 1'b0; b0.ldr_addr = 32'h24;
        b0.cpu_req = 1'b1;
        b0.ldr_req = 1'b1;
        for (int t = 1; t <= 14 && n_ack < 3; t++) begin
            tick();
            if (b0.cpu_ack && b0.ldr_ack) overlap++;
            if (b0.cpu_ack) begin who[n_ack] = 0; when_t[n_ack] = t; n_ack++; end
            else if (b0.ldr_ack) begin who[n_ack] = 1; when_t[n_ack] = t; n_ack++; end
        end
        b0.cpu_req = 1'b0;
        b0.ldr_req = 1'b0;
        checks++; if (n_ack != 3) begin errors++; $display("FAIL rr_ack_count got %0d exp 3", n_ack); end
        checks++; if (who[0] != 0 || who[1] != 1 || who[2] != 0) begin
            errors++; $display("FAIL rr_order got %0d %0d %0d exp 0 1 0", who[0], who[1], who[2]);
        end
        checks++; if (when_t[0] != 3 || when_t[1] != 7 || when_t[2] != 11) begin
            errors++; $display("FAIL rr_ack_times got %0d %0d %0d exp 3 7 11", when_t[0], when_t[1], when_t[2]);
        end
        checks++; if (overlap != 0) begin errors++; $display("FAIL rr_ack_overlap got %0d exp 0", overlap); end
        checks++; if (b0.cpu_rdata !== 32'hCAFE_0020) begin errors++; $display("FAIL rr_cpu_rdata got %h exp cafe0020", b0.cpu_rdata); end
        checks++; if (b0.ldr_rdata !== 32'hCAFE_0024) begin errors++; $display("FAIL rr_ldr_rdata got %h exp cafe0024", b0.ldr_rdata); end
        tick();
    endtask

    task automatic test_ldr_write();
        int lat = 0;
        int we_cnt = 0;
        bit got = 0;
        logic [31:0] we_addr = '0;
        logic [31:0] we_data = '0;
        b3.ldr_we    = 1'b1;
        b3.ldr_addr  = 32'h0000_0040;
        b3.ldr_wdata = 32'h1234_5678;
        b3.ldr_req   = 1'b1;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            lat++;
            if (b3.mem_we) begin we_cnt++; we_addr = b3.mem_addr; we_data = b3.mem_wdata; end
            if (b3.ldr_ack) got = 1;
        end
        b3.ldr_req = 1'b0;
        checks++; if (lat != 5 || !got) begin errors++; $display("FAIL ldr_write_latency got %0d (ack %0d) exp 5", lat, got); end
        checks++; if (we_cnt != 1) begin errors++; $display("FAIL ldr_write_we_cycles got %0d exp 1", we_cnt); end
        checks++; if (we_addr !== 32'h40) begin errors++; $display("FAIL ldr_write_addr got %h exp 40", we_addr); end
        checks++; if (we_data !== 32'h1234_5678) begin errors++; $display("FAIL ldr_write_data got %h exp 12345678", we_data); end
        checks++; if (b3.cpu_ack !== 1'b0) begin errors++; $display("FAIL ldr_write_cpu_ack got %b exp 0", b3.cpu_ack); end
        tick();
        checks++; if (b3.mem_we !== 1'b0 || b3.mem_addr !== 32'h40) begin
            errors++; $display("FAIL ldr_write_hold got we %b addr %h exp 0 40", b3.mem_we, b3.mem_addr);
        end
    endtask

    task automatic test_req_drop();
        int n_ack = 0;
        b0.cpu_we   = 1'b0;
        b0.cpu_addr = 32'h30;
        b0.cpu_req  = 1'b1;
        tick();
        tick();
        b0.cpu_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (b0.cpu_ack) n_ack++;
        end
        checks++; if (n_ack != 1) begin errors++; $display("FAIL req_drop_ack_count got %0d exp 1", n_ack); end
        checks++; if (b0.cpu_rdata !== 32'hCAFE_0030) begin errors++; $display("FAIL req_drop_rdata got %h exp cafe0030", b0.cpu_rdata); end
    endtask

    task automatic test_reset_mid_access();
        int lat = 0;
        bit got = 0;
        b0.cpu_we    = 1'b1;
        b0.cpu_addr  = 32'h50;
        b0.cpu_wdata = 32'h55;
        b0.cpu_req   = 1'b1;
        tick();
        checks++; if (b0.mem_we !== 1'b1) begin errors++; $display("FAIL mid_reset_pre_we got %b exp 1", b0.mem_we); end
        reset = 1'b1;
        #1;
        checks++; if (b0.mem_we !== 1'b0 || b0.mem_addr !== 32'h0 || b0.mem_wdata !== 32'h0) begin
            errors++; $display("FAIL mid_reset_mem got we %b addr %h wdata %h exp 0 0 0", b0.mem_we, b0.mem_addr, b0.mem_wdata);
        end
        checks++; if (b0.cpu_rdata !== 32'h0 || b0.ldr_rdata !== 32'h0) begin
            errors++; $display("FAIL mid_reset_rdata got %h %h exp 0 0", b0.cpu_rdata, b0.ldr_rdata);
        end
        b0.cpu_we   = 1'b0;
        b0.cpu_addr = 32'h60;
        tick();
        checks++; if (b0.cpu_ack !== 1'b0) begin errors++; $display("FAIL mid_reset_no_ack got %b exp 0", b0.cpu_ack); end
        reset = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            lat++;
            if (b0.cpu_ack) got = 1;
        end
        b0.cpu_req = 1'b0;
        checks++; if (lat != 3 || !got) begin errors++; $display("FAIL mid_reset_recover_latency got %0d (ack %0d) exp 3", lat, got); end
        checks++; if (b0.cpu_rdata !== 32'hCAFE_0060) begin errors++; $display("FAIL mid_reset_recover_rdata got %h exp cafe0060", b0.cpu_rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        int when_t[4];
        int n_ack = 0;
        int we_cnt = 0;
        for (int k = 0; k < 4; k++) when_t[k] = -1;
        bz.cpu_we   = 1'b0;
        bz.cpu_addr = 32'h70;
        bz.cpu_req  = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (bz.mem_we) we_cnt++;
            if (bz.cpu_ack) begin
                if (n_ack < 4) when_t[n_ack] = t;
                n_ack++;
            end
        end
        bz.cpu_req = 1'b0;
        checks++; if (n_ack != 4) begin errors++; $display("FAIL b2b_ack_count got %0d exp 4", n_ack); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (when_t[k] != 2 + 3 * k) begin errors++; $display("FAIL b2b_ack_time_%0d got %0d exp %0d", k, when_t[k], 2 + 3 * k); end
        end
        checks++; if (we_cnt != 0) begin errors++; $display("FAIL b2b_mem_we got %0d exp 0", we_cnt); end
        checks++; if (bz.cpu_rdata !== 32'hCAFE_0070) begin errors++; $display("FAIL b2b_rdata got %h exp cafe0070", bz.cpu_rdata); end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        b0.cpu_req = 0; b0.cpu_we = 0; b0.cpu_addr = '0; b0.cpu_wdata = '0;
        b0.ldr_req = 0; b0.ldr_we = 0; b0.ldr_addr = '0; b0.ldr_wdata = '0;
        b3.cpu_req = 0; b3.cpu_we = 0; b3.cpu_addr = '0; b3.cpu_wdata = '0;
        b3.ldr_req = 0; b3.ldr_we = 0; b3.ldr_addr = '0; b3.ldr_wdata = '0;
        bz.cpu_req = 0; bz.cpu_we = 0; bz.cpu_addr = '0; bz.cpu_wdata = '0;
        bz.ldr_req = 0; bz.ldr_we = 0; bz.ldr_addr = '0; bz.ldr_wdata = '0;

        test_reset();
        test_cpu_read();
        test_round_robin();
        test_ldr_write();
        test_req_drop();
        test_reset_mid_access();
        test_back_to_back();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
